// File: rtl/oh_burstgen.sv
// oh_burstgen: programmable pulse-burst generator.
//
// A start request accepted in IDLE latches a pulse count and a gap period.
// The block then emits that many single-cycle pulses on out, separated by
// period idle cycles, and finishes with a one-cycle done strobe.
//
// Build option: define OH_BURSTGEN_REPEAT_EN to add the repeat_burst input
// (the natural name "repeat" is a reserved word). With repeat_burst high in
// the last-pulse cycle the burst restarts seamlessly: done strobes, busy
// stays high and the next pulse keeps the in-burst spacing.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   reset        in   asynchronous active-high reset
//   start        in   request a burst, sampled only in IDLE
//   stop         in   abort current burst, wins over start
//   count[N]     in   pulses per burst, latched on accepted start
//   period[N]    in   idle cycles between pulses, latched on accepted start
//   repeat_burst in   (OH_BURSTGEN_REPEAT_EN only) restart after last pulse
//   out          out  one-cycle pulse
//   busy         out  burst in progress
//   done         out  one-cycle completion strobe
//   remaining[N] out  pulses not yet emitted
//
// State  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for start
// PULSE  | out high, remaining already shows count-k
// GAP    | idle cycles between pulses, gap_q counts down
// FINISH | done strobe, back to IDLE next cycle
module oh_burstgen #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [N-1:0] count,
    input  logic [N-1:0] period,
`ifdef OH_BURSTGEN_REPEAT_EN
    input  logic         repeat_burst,
`endif
    output logic         out,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] remaining
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, PULSE, GAP, FINISH} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] cnt_lat, cnt_d;
    logic [N-1:0] per_lat, per_d;
    logic [N-1:0] gap_q, gap_d;
    logic [N-1:0] rem_d;
    logic         out_d, busy_d, done_d;
    logic         rpt;
    logic         abort;
    logic         restart;

`ifdef OH_BURSTGEN_REPEAT_EN
    assign rpt = repeat_burst;
`else
    assign rpt = 1'b0;
`endif

    assign abort   = stop && (state_q != IDLE);
    assign restart = !abort && (state_q == PULSE) && (remaining == '0) && rpt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop)
                        state_d = (count == '0) ? FINISH : PULSE;
                end
                PULSE: begin
                    if (remaining == '0 && !rpt)
                        state_d = FINISH;
                    else
                        state_d = (per_lat == '0) ? PULSE : GAP;
                end
                GAP: begin
                    // <= 1 rather than == 1 so the counter can never wrap
                    if (gap_q <= ONE)
                        state_d = PULSE;
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values for the registered outputs and datapath. Outputs are
    // decoded from state_d so every output leaves a flop.
    always_comb begin
        out_d  = (state_d == PULSE);
        busy_d = (state_d == PULSE) || (state_d == GAP);
        done_d = (state_d == FINISH) || restart;
        cnt_d  = cnt_lat;
        per_d  = per_lat;
        gap_d  = gap_q;
        rem_d  = remaining;
        if (abort) begin
            rem_d = '0;
            gap_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        cnt_d = count;
                        per_d = period;
                        gap_d = '0;
                        rem_d = (count == '0) ? '0 : count - ONE;
                    end
                end
                PULSE: begin
                    if (state_d == GAP)
                        gap_d = per_lat;
                    if (restart) begin
                        // back-to-back restart consumes a pulse immediately
                        rem_d = (state_d == PULSE) ? cnt_lat - ONE : cnt_lat;
                    end else if (state_d == PULSE && remaining != '0) begin
                        rem_d = remaining - ONE;
                    end
                end
                GAP: begin
                    if (state_d == PULSE) begin
                        gap_d = '0;
                        if (remaining != '0)
                            rem_d = remaining - ONE;
                    end else begin
                        gap_d = gap_q - ONE;
                    end
                end
                FINISH: begin
                    rem_d = '0;
                end
                default: begin
                    rem_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            cnt_lat   <= '0;
            per_lat   <= '0;
            gap_q     <= '0;
        end else begin
            out       <= out_d;
            busy      <= busy_d;
            done      <= done_d;
            remaining <= rem_d;
            cnt_lat   <= cnt_d;
            per_lat   <= per_d;
            gap_q     <= gap_d;
        end
    end

endmodule

// File: tb/tb_oh_burstgen.sv
// Directed testbench for oh_burstgen (N=8). Cycle c is the interval after
// rising edge c-1; start is driven in cycle 0 and sampled at edge 0. Inputs
// change and outputs are sampled on the falling edge.
module tb_oh_burstgen;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic [N-1:0] count;
    logic [N-1:0] period;
`ifdef OH_BURSTGEN_REPEAT_EN
    logic         repeat_burst;
`endif
    logic         out;
    logic         busy;
    logic         done;
    logic [N-1:0] remaining;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oh_burstgen #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .count        (count),
        .period       (period),
`ifdef OH_BURSTGEN_REPEAT_EN
        .repeat_burst (repeat_burst),
`endif
        .out          (out),
        .busy         (busy),
        .done         (done),
        .remaining    (remaining)
    );

    task automatic test_reset();
        logic [2:0] exp_obd;
        logic [N-1:0] exp_rem;
        reset = 1'b1; start = 1'b0; stop = 1'b0; count = '0; period = '0;
`ifdef OH_BURSTGEN_REPEAT_EN
        repeat_burst = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out, busy, done, remaining} !== {3'b000, 8'd0}) begin
            failures++;
            $display("FAIL reset_state out/busy/done/rem=%b%b%b/%0d required 000/0", out, busy, done, remaining);
        end
        reset = 1'b0;
        @(negedge clk);
        // reset in the middle of a count=5 period=3 burst (pulses 1,5,...)
        start = 1'b1; count = 8'd5; period = 8'd3;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin
                checks++;
                if ({out, busy, remaining} !== {2'b11, 8'd3}) begin
                    failures++;
                    $display("FAIL reset_pre_pulse2 out/busy/rem=%b%b/%0d required 11/3", out, busy, remaining);
                end
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({out, busy, done, remaining} !== {3'b000, 8'd0}) begin
            failures++;
            $display("FAIL reset_mid_burst out/busy/done/rem=%b%b%b/%0d required 000/0", out, busy, done, remaining);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // fresh burst count=2 period=0: pulses 1,2 done 3
        start = 1'b1; count = 8'd2; period = 8'd0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_obd = (c == 1) ? 3'b110 : (c == 2) ? 3'b110 : (c == 3) ? 3'b001 : 3'b000;
            exp_rem = (c == 1) ? 8'd1 : 8'd0;
            checks++;
            if ({out, busy, done, remaining} !== {exp_obd, exp_rem}) begin
                failures++;
                $display("FAIL reset_fresh cycle %0d out/busy/done/rem=%b%b%b/%0d required %b/%0d", c, out, busy, done, remaining, exp_obd, exp_rem);
            end
        end
    endtask

    task automatic test_count4_period2();
        logic exp_out, exp_busy, exp_done;
        logic [N-1:0] exp_rem;
        @(negedge clk);
        start = 1'b1; count = 8'd4; period = 8'd2;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            // latched values must not follow the inputs after acceptance
            start = 1'b0; count = 8'hAA; period = 8'h55;
            exp_out  = (c == 1) || (c == 4) || (c == 7) || (c == 10);
            exp_busy = (c <= 10);
            exp_done = (c == 11);
            exp_rem  = (c == 1) ? 8'd3 : (c == 4) ? 8'd2 : (c == 7) ? 8'd1 : 8'd0;
            checks++;
            if ({out, busy, done} !== {exp_out, exp_busy, exp_done}) begin
                failures++;
                $display("FAIL c4p2 cycle %0d out/busy/done=%b%b%b required %b%b%b", c, out, busy, done, exp_out, exp_busy, exp_done);
            end
            if (exp_out) begin
                checks++;
                if (remaining !== exp_rem) begin
                    failures++;
                    $display("FAIL c4p2_rem cycle %0d remaining=%0d required %0d", c, remaining, exp_rem);
                end
            end
        end
    endtask

    task automatic test_period0_and_zero();
        logic [2:0] exp_obd;
        @(negedge clk);
        start = 1'b1; count = 8'd3; period = 8'd0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_obd = (c <= 3) ? 3'b110 : (c == 4) ? 3'b001 : 3'b000;
            checks++;
            if ({out, busy, done} !== exp_obd) begin
                failures++;
                $display("FAIL c3p0 cycle %0d out/busy/done=%b%b%b required %b", c, out, busy, done, exp_obd);
            end
        end
        start = 1'b1; count = 8'd0; period = 8'd4;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_obd = (c == 1) ? 3'b001 : 3'b000;
            checks++;
            if ({out, busy, done} !== exp_obd) begin
                failures++;
                $display("FAIL count0 cycle %0d out/busy/done=%b%b%b required %b", c, out, busy, done, exp_obd);
            end
        end
    endtask

    task automatic test_stop();
        logic [2:0] exp_obd;
        @(negedge clk);
        start = 1'b1; count = 8'd6; period = 8'd1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            exp_obd = (c == 1 || c == 3) ? 3'b110 : (c <= 4) ? 3'b010 : 3'b000;
            checks++;
            if ({out, busy, done} !== exp_obd) begin
                failures++;
                $display("FAIL stop cycle %0d out/busy/done=%b%b%b required %b", c, out, busy, done, exp_obd);
            end
            if (c == 3 || c >= 5) begin
                checks++;
                if (remaining !== ((c == 3) ? 8'd4 : 8'd0)) begin
                    failures++;
                    $display("FAIL stop_rem cycle %0d remaining=%0d required %0d", c, remaining, (c == 3) ? 4 : 0);
                end
            end
            // start while busy (with a different count) must be ignored
            start = (c == 2);
            count = (c == 2) ? 8'd1 : 8'd6;
            stop  = (c == 4);
        end
        // stop in IDLE blocks a simultaneous start
        start = 1'b1; stop = 1'b1; count = 8'd3; period = 8'd0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            checks++;
            if ({out, busy, done} !== 3'b000) begin
                failures++;
                $display("FAIL stop_idle cycle %0d out/busy/done=%b%b%b required 000", c, out, busy, done);
            end
        end
    endtask

    task automatic test_boundary();
        logic exp_out, exp_done;
        @(negedge clk);
        start = 1'b1; count = 8'd255; period = 8'd0;
        for (int c = 1; c <= 257; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_out  = (c <= 255);
            exp_done = (c == 256);
            checks++;
            if ({out, busy, done} !== {exp_out, exp_out, exp_done}) begin
                failures++;
                $display("FAIL max_count cycle %0d out/busy/done=%b%b%b required %b%b%b", c, out, busy, done, exp_out, exp_out, exp_done);
            end
            if (c == 1 || c == 255) begin
                checks++;
                if (remaining !== ((c == 1) ? 8'd254 : 8'd0)) begin
                    failures++;
                    $display("FAIL max_count_rem cycle %0d remaining=%0d required %0d", c, remaining, (c == 1) ? 254 : 0);
                end
            end
        end
        start = 1'b1; count = 8'd2; period = 8'd255;
        for (int c = 1; c <= 259; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_out  = (c == 1) || (c == 257);
            exp_done = (c == 258);
            checks++;
            if ({out, busy, done} !== {exp_out, (c <= 257), exp_done}) begin
                failures++;
                $display("FAIL max_period cycle %0d out/busy/done=%b%b%b required %b%b%b", c, out, busy, done, exp_out, (c <= 257), exp_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_obd;
        @(negedge clk);
        start = 1'b1; count = 8'd1; period = 8'd0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            // start held through the done cycle: ignored there, taken in
            // the following IDLE cycle -> second pulse in cycle 4
            start = (c == 2) || (c == 3);
            exp_obd = (c == 1 || c == 4) ? 3'b110 : (c == 2 || c == 5) ? 3'b001 : 3'b000;
            checks++;
            if ({out, busy, done} !== exp_obd) begin
                failures++;
                $display("FAIL back_to_back cycle %0d out/busy/done=%b%b%b required %b", c, out, busy, done, exp_obd);
            end
        end
        start = 1'b0;
    endtask

`ifdef OH_BURSTGEN_REPEAT_EN
    task automatic test_repeat();
        logic exp_out, exp_busy, exp_done;
        logic [N-1:0] exp_rem;
        @(negedge clk);
        start = 1'b1; count = 8'd2; period = 8'd1; repeat_burst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 6) repeat_burst = 1'b0;
            exp_out  = (c == 1) || (c == 3) || (c == 5) || (c == 7);
            exp_busy = (c <= 7);
            exp_done = (c == 4) || (c == 8);
            exp_rem  = (c == 1 || c == 2 || c == 5 || c == 6) ? 8'd1 : (c == 4) ? 8'd2 : 8'd0;
            checks++;
            if ({out, busy, done, remaining} !== {exp_out, exp_busy, exp_done, exp_rem}) begin
                failures++;
                $display("FAIL repeat cycle %0d out/busy/done/rem=%b%b%b/%0d required %b%b%b/%0d", c, out, busy, done, remaining, exp_out, exp_busy, exp_done, exp_rem);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count4_period2();
        test_period0_and_zero();
        test_stop();
        test_boundary();
        test_back_to_back();
`ifdef OH_BURSTGEN_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
